// File: rtl/gpio_led_sequencer_pkg.sv
// Shared definitions for the GPIO LED chain sequencer: FSM encodings, requester IDs, defaults.
// The optional chain-clear phase is selected with the LED_CLR_EN macro in the top.
package gpio_led_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } led_state_e;

    localparam int REQ_CPU  = 0;
    localparam int REQ_SCAN = 1;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_CLR_CYCLES = 2;
    localparam int DEF_PEN_CYCLES = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_rr_arb2.sv
// Two-way round-robin arbiter for the LED chain; pointer low favours the CPU requester.
module led_rr_arb2
    import gpio_led_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic       ptr_r;
    logic [1:0] gnt_s;

    // Grant decision: with both requesting, the pointer picks the one not served last.
    always_comb begin
        gnt_s = 2'b00;
        if (enable) begin
            if (req[REQ_CPU] && (!req[REQ_SCAN] || (ptr_r == 1'b0))) begin
                gnt_s[REQ_CPU] = 1'b1;
            end else if (req[REQ_SCAN]) begin
                gnt_s[REQ_SCAN] = 1'b1;
            end else begin
                gnt_s = 2'b00;
            end
        end else begin
            gnt_s = 2'b00;
        end
    end

    // Pointer update: after any grant, favour the other requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (gnt_s[REQ_CPU]) begin
            ptr_r <= 1'b1;
        end else if (gnt_s[REQ_SCAN]) begin
            ptr_r <= 1'b0;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/gpio_led_sequencer.sv
// Arbitrates CPU and scan LED frames, shifts them MSB-first onto the LED chain and latches them.
// Define LED_CLR_EN to build the chain-clear phase (led_clrn low before every frame).
module gpio_led_sequencer
    import gpio_led_sequencer_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int CLR_CYCLES = DEF_CLR_CYCLES,
    parameter int PEN_CYCLES = DEF_PEN_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_gnt,
    input  logic              scan_req,
    input  logic [DATA_W-1:0] scan_data,
    output logic              scan_gnt,
    output logic              busy,
    output logic              frame_done,
    output logic              led_clk,
    output logic              led_sout,
    output logic              led_clrn,
    output logic              LED_PEN,
    output logic [DATA_W-1:0] LED_out
);

    localparam int PH_W   = cnt_w(2 * CLK_DIV);
    localparam int BIT_W  = cnt_w(DATA_W);
    localparam int HOLD_W = cnt_w((CLR_CYCLES > PEN_CYCLES) ? CLR_CYCLES : PEN_CYCLES);

    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_HIGH  = PH_W'(CLK_DIV);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [HOLD_W-1:0] PEN_LAST = HOLD_W'(PEN_CYCLES - 1);
`ifdef LED_CLR_EN
    localparam logic [HOLD_W-1:0] CLR_LAST = HOLD_W'(CLR_CYCLES - 1);
`endif

    led_state_e        state_r, state_nxt_s;
    logic [PH_W-1:0]   phase_r, phase_nxt_s;
    logic [BIT_W-1:0]  bit_r, bit_nxt_s;
    logic [HOLD_W-1:0] hold_r, hold_nxt_s;
    logic [DATA_W-1:0] shift_r, shift_nxt_s;
    logic [DATA_W-1:0] frame_r, frame_nxt_s;
    logic [1:0]        gnt_s;
    logic              arb_en_s;
    logic              led_clrn_nxt_s;
    logic              busy_r, frame_done_r, led_clk_r, led_sout_r, led_clrn_r, led_pen_r;
    logic [DATA_W-1:0] led_out_r;

    // Grants only in IDLE, and never while reset is held so no pulse escapes during reset.
    assign arb_en_s = (state_r == ST_IDLE) && !rst;

    led_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({scan_req, cpu_req}),
        .enable (arb_en_s),
        .gnt    (gnt_s)
    );

    // Next-state logic: frame capture, chain clear, bit serialisation, latch and done.
    always_comb begin
        state_nxt_s    = state_r;
        phase_nxt_s    = phase_r;
        bit_nxt_s      = bit_r;
        hold_nxt_s     = hold_r;
        shift_nxt_s    = shift_r;
        frame_nxt_s    = frame_r;
        led_clrn_nxt_s = 1'b1;
        case (state_r)
            ST_IDLE: begin
                phase_nxt_s = '0;
                bit_nxt_s   = '0;
                hold_nxt_s  = '0;
                if (|gnt_s) begin
                    frame_nxt_s = gnt_s[REQ_SCAN] ? scan_data : cpu_data;
                    shift_nxt_s = gnt_s[REQ_SCAN] ? scan_data : cpu_data;
`ifdef LED_CLR_EN
                    state_nxt_s = ST_CLEAR;
`else
                    state_nxt_s = ST_SHIFT;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifdef LED_CLR_EN
            ST_CLEAR: begin
                if (hold_r == CLR_LAST) begin
                    hold_nxt_s  = '0;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    hold_nxt_s = hold_r + HOLD_W'(1);
                end
            end
`endif
            ST_SHIFT: begin
                if (phase_r == PH_LAST) begin
                    phase_nxt_s = '0;
                    shift_nxt_s = {shift_r[DATA_W-2:0], 1'b0};
                    if (bit_r == BIT_LAST) begin
                        bit_nxt_s   = '0;
                        state_nxt_s = ST_LATCH;
                    end else begin
                        bit_nxt_s = bit_r + BIT_W'(1);
                    end
                end else begin
                    phase_nxt_s = phase_r + PH_W'(1);
                end
            end
            ST_LATCH: begin
                if (hold_r == PEN_LAST) begin
                    hold_nxt_s  = '0;
                    state_nxt_s = ST_DONE;
                end else begin
                    hold_nxt_s = hold_r + HOLD_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
`ifdef LED_CLR_EN
        led_clrn_nxt_s = (state_nxt_s != ST_CLEAR);
`else
        led_clrn_nxt_s = 1'b1;
`endif
    end

    // FSM, counters and frame registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            phase_r <= '0;
            bit_r   <= '0;
            hold_r  <= '0;
            shift_r <= '0;
            frame_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            phase_r <= phase_nxt_s;
            bit_r   <= bit_nxt_s;
            hold_r  <= hold_nxt_s;
            shift_r <= shift_nxt_s;
            frame_r <= frame_nxt_s;
        end
    end

    // Chain outputs are registered from next-state values so they are glitch-free and cycle-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            led_clk_r    <= 1'b0;
            led_sout_r   <= 1'b0;
            led_clrn_r   <= 1'b1;
            led_pen_r    <= 1'b0;
            led_out_r    <= '0;
        end else begin
            busy_r       <= (state_nxt_s != ST_IDLE);
            frame_done_r <= (state_nxt_s == ST_DONE);
            led_clk_r    <= (state_nxt_s == ST_SHIFT) && (phase_nxt_s >= PH_HIGH);
            led_sout_r   <= (state_nxt_s == ST_SHIFT) ? shift_nxt_s[DATA_W-1] : 1'b0;
            led_clrn_r   <= led_clrn_nxt_s;
            led_pen_r    <= (state_nxt_s == ST_LATCH);
            if ((state_nxt_s == ST_LATCH) && (state_r != ST_LATCH)) begin
                led_out_r <= frame_r;
            end else begin
                led_out_r <= led_out_r;
            end
        end
    end

    assign cpu_gnt    = gnt_s[REQ_CPU];
    assign scan_gnt   = gnt_s[REQ_SCAN];
    assign busy       = busy_r | (|gnt_s);
    assign frame_done = frame_done_r;
    assign led_clk    = led_clk_r;
    assign led_sout   = led_sout_r;
    assign led_clrn   = led_clrn_r;
    assign LED_PEN    = led_pen_r;
    assign LED_out    = led_out_r;

endmodule
